// File: rtl/rtc_timestamp.sv
// Time-of-day/day counter with prescaler, validated time-set port and event timestamp capture.
// Latency: outputs registered, one edge after the inputs; no flow control, capture and set never stall.
// Backpressure: none, every set request is accepted or rejected on its own edge.
module rtc_timestamp #(
    parameter int CLK_DIV  = 1,
    parameter int HOUR_MOD = 24,
    parameter int DAY_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              set_valid,
    input  logic [DAY_W-1:0]  set_day,
    input  logic [4:0]        set_hours,
    input  logic [5:0]        set_minutes,
    input  logic [5:0]        set_seconds,
    output logic              set_err,
    input  logic              event_in,
    output logic [DAY_W+16:0] horario,
    output logic              sec_tick,
    output logic [DAY_W+16:0] stamp,
    output logic              stamp_valid
);

    localparam int             PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST  = PW'(CLK_DIV - 1);
    localparam logic [5:0]     HOUR_LIM  = 6'(HOUR_MOD);
    localparam logic [4:0]     HOUR_LAST = 5'(HOUR_MOD - 1);
    localparam logic [5:0]     SIXTY     = 6'd60;
    localparam logic [5:0]     LAST_MS   = 6'd59;

    logic [PW-1:0]      pre_q, pre_d;
    logic [DAY_W-1:0]   day_q, day_d;
    logic [4:0]         hr_q, hr_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic               tick_q, tick_d;
    logic               err_q, err_d;
    logic [DAY_W+16:0]  stamp_q, stamp_d;
    logic               stv_q, stv_d;

    logic tick;
    logic set_in_range;
    logic set_ok;

    assign tick         = en && (pre_q == PRE_LAST);
    assign set_in_range = ({1'b0, set_hours} < HOUR_LIM) && (set_minutes < SIXTY)
                          && (set_seconds < SIXTY);
    assign set_ok       = set_valid && set_in_range;

    assign horario     = {day_q, hr_q, min_q, sec_q};
    assign sec_tick    = tick_q;
    assign set_err     = err_q;
    assign stamp       = stamp_q;
    assign stamp_valid = stv_q;

    always_comb begin
        pre_d   = pre_q;
        day_d   = day_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        err_d   = set_valid && !set_in_range;
        stamp_d = stamp_q;
        stv_d   = stv_q;

        // A valid set wins over a coincident tick; the tick is simply lost.
        if (set_ok) begin
            pre_d = '0;
            day_d = set_day;
            hr_d  = set_hours;
            min_d = set_minutes;
            sec_d = set_seconds;
        end else if (tick) begin
            pre_d  = '0;
            tick_d = 1'b1;
            if (sec_q == LAST_MS) begin
                sec_d = '0;
                if (min_q == LAST_MS) begin
                    min_d = '0;
                    if (hr_q == HOUR_LAST) begin
                        hr_d  = '0;
                        day_d = day_q + DAY_W'(1);
                    end else begin
                        hr_d = hr_q + 5'd1;
                    end
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end else if (en) begin
            pre_d = pre_q + PW'(1);
        end

        // Capture always sees the time as it stood before this edge.
        if (event_in) begin
            stamp_d = horario;
            stv_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            day_q   <= '0;
            hr_q    <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
            stamp_q <= '0;
            stv_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            day_q   <= day_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
            stamp_q <= stamp_d;
            stv_q   <= stv_d;
        end
    end

endmodule
